// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types: pixel type, default column width, feeder state enum
package fpu_pkg;

  typedef logic [7:0] pixel_t;

  localparam int unsigned COL_WIDTH_DEF = 10;

  // Total shifts per strip can reach 65535 + 2 pad columns, so 17 bits.
  localparam int unsigned FEEDER_CNT_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PUSH = 2'd2,
    ST_DONE = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/fpu_col_feeder.sv
// rtl/fpu_col_feeder.sv - assembles pixel columns and strobes them into the FPU column buffers (optional FPU_FEEDER_PAD_EN: zero border columns)
module fpu_col_feeder
  import fpu_pkg::*;
#(
  parameter int COL_WIDTH = COL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            num_cols,
  input  logic                   in_valid,
  input  pixel_t                 in_data,
  output logic                   in_ready,
  input  logic                   col_ready,
  output logic                   shift_rows,
  output pixel_t [COL_WIDTH-1:0] col_new,
  output logic                   window_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int IDX_W = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL_WIDTH - 1);

  feeder_state_t             state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [FEEDER_CNT_W-1:0]   cnt_q;
  logic [FEEDER_CNT_W-1:0]   total_q;
  logic [FEEDER_CNT_W-1:0]   cnt_next;

  assign cnt_next = cnt_q + 1'b1;

  // Next-state and strobe decode; PUSH holds until the buffers can shift.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    shift_rows = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_cols == 16'd0) begin
            state_d = ST_DONE;
          end else begin
`ifdef FPU_FEEDER_PAD_EN
            state_d = ST_PUSH;
`else
            state_d = ST_FILL;
`endif
          end
        end
      end
      ST_FILL: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && idx_q == LAST_IDX) begin
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        busy       = 1'b1;
        shift_rows = col_ready;
        if (col_ready) begin
          if (cnt_next == total_q) begin
            state_d = ST_DONE;
`ifdef FPU_FEEDER_PAD_EN
          end else if (cnt_next + 1'b1 == total_q) begin
            state_d = ST_PUSH;
`endif
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pixel index, shift count and the column being assembled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      total_q      <= '0;
      col_new      <= '0;
      window_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            window_valid <= 1'b0;
`ifdef FPU_FEEDER_PAD_EN
            total_q      <= {1'b0, num_cols} + 17'd2;
            col_new      <= '0;
`else
            total_q      <= {1'b0, num_cols};
`endif
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            col_new[idx_q] <= in_data;
            idx_q          <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          end
        end
        ST_PUSH: begin
          if (col_ready) begin
            cnt_q <= cnt_next;
            if (cnt_q == 17'd2) begin
              window_valid <= 1'b1;
            end
`ifdef FPU_FEEDER_PAD_EN
            // Trailing border column: blank the buffer and push again without filling.
            if (cnt_next + 1'b1 == total_q) begin
              col_new <= '0;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_col_feeder.sv
// tb/tb_fpu_col_feeder.sv - directed table-driven bench for fpu_col_feeder (honours FPU_FEEDER_PAD_EN)
module tb_fpu_col_feeder;

  localparam int W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [15:0]       num_cols;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              col_ready;
  logic              shift_rows;
  logic [W-1:0][7:0] col_new;
  logic              window_valid;
  logic              busy;
  logic              done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_col_feeder #(.COL_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_cols     (num_cols),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .col_ready    (col_ready),
    .shift_rows   (shift_rows),
    .col_new      (col_new),
    .window_valid (window_valid),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    int n;
    bit toggle;
    int stall;
    int restart_at;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_total(input int n);
`ifdef FPU_FEEDER_PAD_EN
    return (n == 0) ? 0 : n + 2;
`else
    return n;
`endif
  endfunction

  function automatic bit is_data_shift(input int s, input int n);
`ifdef FPU_FEEDER_PAD_EN
    return (s >= 1) && (s <= n);
`else
    return (s >= 0) && (s < n);
`endif
  endfunction

  function automatic logic [W*8-1:0] exp_col(input int s, input int n);
    logic [W*8-1:0] c;
    int d;
    c = '0;
`ifdef FPU_FEEDER_PAD_EN
    if (s == 0 || s == n + 1) return c;
    d = s - 1;
`else
    d = (s < n) ? s : 0;
`endif
    for (int r = 0; r < W; r++) c[r*8 +: 8] = 8'(d * W + r + 1);
    return c;
  endfunction

  task automatic run_strip(input vec_t v);
    int total_pix;
    int tot;
    int next_pix;
    int shifts;
    int cyc;
    int last_acc;
    int last_shift;
    int stall_left;
    bit stalled;
    bit restarted;
    bit seen_done;
    total_pix  = v.n * W;
    tot        = exp_total(v.n);
    next_pix   = 1;
    shifts     = 0;
    cyc        = 0;
    last_acc   = -100;
    last_shift = -1;
    stall_left = v.stall;
    stalled    = 1'b0;
    restarted  = 1'b0;
    seen_done  = 1'b0;
    start      = 1'b1;
    num_cols   = 16'(v.n);
    in_valid   = 1'b0;
    col_ready  = 1'b1;
    step();
    start = 1'b0;
    while (!seen_done && cyc < 2000) begin
      start = 1'b0;
      if (v.restart_at != 0 && !restarted && next_pix == v.restart_at + 1) begin
        start     = 1'b1;
        num_cols  = 16'd5;
        restarted = 1'b1;
      end
      in_valid  = v.toggle ? ((cyc % 2) == 0) : 1'b1;
      in_data   = 8'(next_pix);
      col_ready = 1'b1;
      #1;
      if (busy && !in_ready && stall_left > 0) begin
        col_ready = 1'b0;
        stall_left--;
        stalled = 1'b1;
      end
      #1;
      check("window_valid", 128'(window_valid), 128'(shifts >= 3));
      check("in_ready_extra", 128'(in_ready && next_pix > total_pix), 128'(0));
      if (!col_ready) begin
        check("stall_shift", 128'(shift_rows), 128'(0));
        check("stall_in_ready", 128'(in_ready), 128'(0));
        check("stall_col", 128'(col_new), 128'(exp_col(shifts, v.n)));
      end
      if (shift_rows) begin
        check("col_new", 128'(col_new), 128'(exp_col(shifts, v.n)));
        check("shift_excess", 128'(shifts < tot), 128'(1));
        if (!stalled && is_data_shift(shifts, v.n))
          check("shift_latency", 128'(cyc), 128'(last_acc + 1));
        stalled    = 1'b0;
        last_shift = cyc;
        shifts++;
      end
      if (in_valid && in_ready) begin
        last_acc = cyc;
        next_pix++;
      end
      if (done) begin
        seen_done = 1'b1;
        check("shift_count", 128'(shifts), 128'(tot));
        check("done_timing", 128'(cyc), 128'(last_shift + 1));
        check("busy_in_done", 128'(busy), 128'(0));
      end
      step();
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    check("done_seen", 128'(seen_done), 128'(1));
    check("done_pulse_width", 128'(done), 128'(0));
    check("window_valid_hold", 128'(window_valid), 128'(tot >= 3));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_col_new"}, 128'(col_new), 128'(0));
    check({tag, "_window_valid"}, 128'(window_valid), 128'(0));
    check({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    check({tag, "_shift_rows"}, 128'(shift_rows), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
  endtask

  initial begin
    int pix;
    int guard;
    vec_t one;
    vecs[0] = '{n: 4, toggle: 1'b0, stall: 0, restart_at: 0};
    vecs[1] = '{n: 2, toggle: 1'b0, stall: 5, restart_at: 0};
    vecs[2] = '{n: 4, toggle: 1'b1, stall: 0, restart_at: 0};
    vecs[3] = '{n: 0, toggle: 1'b0, stall: 0, restart_at: 0};
    vecs[4] = '{n: 2, toggle: 1'b0, stall: 0, restart_at: 3};
    vecs[5] = '{n: 1, toggle: 1'b0, stall: 0, restart_at: 0};

    rst_n     = 1'b0;
    start     = 1'b0;
    num_cols  = 16'd0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    col_ready = 1'b0;
    step();
    step();
    check_quiet("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_strip(vecs[i]);

    // Reset in the middle of the second column.
    start     = 1'b1;
    num_cols  = 16'd3;
    in_valid  = 1'b0;
    col_ready = 1'b1;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    pix      = 0;
    guard    = 0;
    while (pix < 16 && guard < 200) begin
      in_data = 8'(pix + 1);
      #1;
      if (in_ready) pix++;
      step();
      guard++;
    end
    check("pre_reset_pixels", 128'(pix), 128'(16));
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_quiet("async_reset");
    step();
    check_quiet("held_reset");
    rst_n = 1'b1;
    step();
    check_quiet("after_reset");
    one = '{n: 1, toggle: 1'b0, stall: 0, restart_at: 0};
    run_strip(one);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
